// File: rtl/ahb_inf_if.sv
// ahb_inf_if: AHB-Lite slave-side bus bundle.
// hready is the bus-level HREADY returned to every slave.
interface ahb_inf_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [3:0]            hprot;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hready;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hreadyout;
  logic                  hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize,
    output hburst, hprot, hwdata, hready,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize,
    input  hburst, hprot, hwdata, hready,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_inf.sv
// ahb_inf: AHB-Lite slave with local word memory,
// wait-state insertion and a two-cycle ERROR response.
module ahb_inf #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic     hclk,
  input  logic     hresetn,
  ahb_inf_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int AW    = IDX_W + 2;
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'(4 * MEM_DEPTH);
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } st_e;

  typedef struct packed {
    logic          valid;
    logic          write;
    logic          err;
    logic [2:0]    size;
    logic [AW-1:0] addr;
  } dph_t;

  st_e  st_q, st_d;
  dph_t dph_q, dph_d;

  logic [2:0] wait_q, wait_d;
  logic       rdy_q, rdy_d;
  logic       resp_q, resp_d;

  logic accept;
  logic misalign;
  logic acc_err;

  logic [3:0]            be;
  logic [IDX_W-1:0]      idx;
  logic                  mem_we;
  logic                  rd_act;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic unused_ok;
  assign unused_ok = ^{bus.hburst, bus.hprot};

  // Address phase decode and error classification
  always_comb begin
    accept = bus.hsel & bus.hready
           & bus.htrans[1] & rdy_q;
    misalign = 1'b0;
    unique case (1'b1)
      bus.hsize == 3'd1: misalign = bus.haddr[0];
      bus.hsize == 3'd2: misalign = |bus.haddr[1:0];
      default:           misalign = 1'b0;
    endcase
    acc_err = ({1'b0, bus.haddr} >= LIMIT)
            | (bus.hsize > 3'd2)
            | misalign;
  end

  always_comb begin
    st_d   = st_q;
    dph_d  = dph_q;
    wait_d = wait_q;
    unique case (st_q)
      ST_WAIT: begin
        if (wait_q <= 3'd1) begin
          wait_d = 3'd0;
          st_d   = ST_DATA;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      ST_ERR1: st_d = ST_ERR2;
      default: begin
        // slot is free: previous data phase ends this edge
        st_d        = ST_IDLE;
        dph_d.valid = 1'b0;
        if (accept) begin
          dph_d.valid = 1'b1;
          dph_d.write = bus.hwrite;
          dph_d.err   = acc_err;
          dph_d.size  = bus.hsize;
          dph_d.addr  = bus.haddr[AW-1:0];
          if (acc_err) begin
            st_d = ST_ERR1;
          end else if (WS != 3'd0) begin
            st_d   = ST_WAIT;
            wait_d = WS;
          end else begin
            st_d = ST_DATA;
          end
        end
      end
    endcase
    rdy_d  = (st_d == ST_IDLE)
           | (st_d == ST_DATA)
           | (st_d == ST_ERR2);
    resp_d = (st_d == ST_ERR1)
           | (st_d == ST_ERR2);
  end

  always_comb begin
    be = 4'b1111;
    unique case (1'b1)
      dph_q.size == 3'd0:
        be = 4'b0001 << dph_q.addr[1:0];
      dph_q.size == 3'd1:
        be = dph_q.addr[1] ? 4'b1100 : 4'b0011;
      default:
        be = 4'b1111;
    endcase
  end

  assign idx     = dph_q.addr[AW-1:2];
  assign rd_word = mem[idx];

  always_comb begin
    wr_word = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        wr_word[8*b +: 8] = bus.hwdata[8*b +: 8];
      end
    end
  end

  // A reset on the commit edge drops the pending write
  assign mem_we = (st_q == ST_DATA)
                & dph_q.write & ~hresetn;
  assign rd_act = dph_q.valid & ~dph_q.write
                & ~dph_q.err;

  always_ff @(posedge hclk) begin
    if (hresetn) begin
      st_q   <= ST_IDLE;
      dph_q  <= '0;
      wait_q <= 3'd0;
      rdy_q  <= 1'b1;
      resp_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      dph_q  <= dph_d;
      wait_q <= wait_d;
      rdy_q  <= rdy_d;
      resp_q <= resp_d;
    end
  end

  always_ff @(posedge hclk) begin
    if (mem_we) begin
      mem[idx] <= wr_word;
    end
  end

  assign bus.hrdata    = rd_act ? rd_word : '0;
  assign bus.hreadyout = rdy_q;
  assign bus.hresp     = resp_q;
endmodule

// File: tb/tb_ahb_inf.sv
// tb_ahb_inf: random AHB-Lite traffic against a byte-level
// memory model, plus a wait-state instance with reset abort.
module tb_ahb_inf;
  localparam int AW    = 32;
  localparam int DEPTH = 256;
  localparam int LIM   = 4 * DEPTH;
  localparam int WIN   = 128;

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    bit          write;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  logic hclk = 1'b0;
  logic rst0, rst2;
  always #5 hclk = ~hclk;

  ahb_inf_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) m0();
  ahb_inf_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) m2();
  assign m0.hready = m0.hreadyout;
  assign m2.hready = m2.hreadyout;

  ahb_inf #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(32),
    .MEM_DEPTH(DEPTH), .WAIT_STATES(0)
  ) u0 (.hclk(hclk), .hresetn(rst0), .bus(m0));

  ahb_inf #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(32),
    .MEM_DEPTH(DEPTH), .WAIT_STATES(2)
  ) u2 (.hclk(hclk), .hresetn(rst2), .bus(m2));

  txn_t txq[$];
  exp_t sb[$];
  logic [7:0] ref_mem [LIM];
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 0;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void fail_now(string msg);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", msg);
  endfunction

  function automatic logic [31:0] lanes(logic [31:0] v,
      logic [31:0] a, logic [2:0] s);
    logic [31:0] m;
    m = (s == 0) ? 32'hFF : (s == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
    m = m << (8 * a[1:0]);
    return ((v << (8 * a[1:0])) & m) | ($urandom & ~m);
  endfunction

  function automatic txn_t mk(bit w, logic [31:0] a,
      logic [2:0] s, logic [31:0] d,
      logic [1:0] tr = 2'd2, logic [2:0] b = 3'd0);
    txn_t t;
    t.sel = 1; t.trans = tr; t.write = w; t.addr = a;
    t.size = s; t.burst = b; t.wdata = d;
    return t;
  endfunction

  function automatic txn_t mk_idle(bit sel, logic [1:0] tr);
    txn_t t;
    t = mk(0, $urandom, 3'd2, $urandom, tr);
    t.sel = sel;
    return t;
  endfunction

  function automatic bit is_x(txn_t t);
    return t.sel && t.trans[1];
  endfunction

  function automatic bit is_err(logic [31:0] a, logic [2:0] s);
    if (a >= LIM) return 1;
    if (s > 3'd2) return 1;
    return (a & ((32'd1 << s) - 1)) != 0;
  endfunction

  // Reference model: transfers take effect in bus order
  function automatic void on_accept(txn_t t);
    exp_t e;
    int base;
    e.write = t.write;
    e.err   = is_err(t.addr, t.size);
    e.rdata = '0;
    if (!e.err) begin
      if (t.write) begin
        for (int k = 0; k < (1 << t.size); k++)
          ref_mem[t.addr + k] = t.wdata[8*(t.addr[1:0] + k) +: 8];
      end else begin
        base = int'(t.addr) & ~3;
        e.rdata = {ref_mem[base+3], ref_mem[base+2],
                   ref_mem[base+1], ref_mem[base]};
      end
    end
    sb.push_back(e);
  endfunction

  task automatic present(txn_t t);
    m0.hsel   = t.sel;
    m0.htrans = t.trans;
    m0.haddr  = t.addr;
    m0.hwrite = t.write;
    m0.hsize  = t.size;
    m0.hburst = t.burst;
    m0.hprot  = 4'h3;
  endtask

  function automatic txn_t pop_or_idle();
    if (txq.size() > 0) return txq.pop_front();
    return mk_idle(0, 2'd0);
  endfunction

  // Monitor: follows data phases seen on the bus
  bit   mdp = 0;
  int   cyc = 0;
  logic c1resp = 0;
  always @(negedge hclk) begin
    exp_t e;
    if (mon_en) begin
      if (mdp) begin
        cyc++;
        if (!m0.hreadyout) begin
          if (cyc == 1) c1resp = m0.hresp;
          if (cyc > 10) begin
            fail_now("mon_stall: data phase never completed");
            mdp = 0;
          end
        end else begin
          mdp = 0;
          if (sb.size() == 0) begin
            fail_now("sb_empty: response with no pending transfer");
          end else begin
            e = sb.pop_front();
            chk("hresp", m0.hresp, e.err);
            if (e.err) begin
              chk("err_cycles", cyc, 2);
              chk("err_c1_hresp", c1resp, 1);
            end else begin
              chk("zero_wait", cyc, 1);
              if (e.write) chk("wr_hrdata_zero", m0.hrdata, 0);
              else chk("hrdata", m0.hrdata, e.rdata);
            end
          end
        end
      end else begin
        chk("idle_outputs",
            {m0.hreadyout, m0.hresp, m0.hrdata},
            {1'b1, 1'b0, 32'h0});
      end
      if (!mdp && m0.hsel && m0.hreadyout && m0.htrans[1]) begin
        mdp = 1;
        cyc = 0;
        c1resp = 0;
      end
    end
  end

  task automatic u2_xfer(input bit w, input logic [31:0] a,
      input logic [31:0] d, output int waits,
      output logic [31:0] rdat, output logic resp);
    bit got = 0;
    m2.hsel = 1; m2.htrans = 2'd2; m2.haddr = a;
    m2.hwrite = w; m2.hsize = 3'd2;
    @(posedge hclk); #1;
    m2.hsel = 0; m2.htrans = 2'd0; m2.hwdata = d;
    waits = 0; rdat = '0; resp = 0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge hclk);
      if (m2.hreadyout) begin
        got = 1; rdat = m2.hrdata; resp = m2.hresp;
      end else begin
        waits++;
      end
    end
    if (!got) fail_now("u2_timeout: hreadyout never returned high");
    @(posedge hclk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t cur, dph;
    bit dph_v, rdy;
    int stall, w;
    logic [31:0] rd;
    logic rs;

    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    present(mk_idle(0, 2'd0));
    m0.hwdata = '0;
    m2.hsel = 0; m2.htrans = 0; m2.haddr = 0; m2.hwrite = 0;
    m2.hsize = 3'd2; m2.hburst = 0; m2.hprot = 0; m2.hwdata = 0;
    rst0 = 1; rst2 = 1;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    chk("rst_u0", {m0.hreadyout, m0.hresp, m0.hrdata},
        {1'b1, 1'b0, 32'h0});
    chk("rst_u2", {m2.hreadyout, m2.hresp, m2.hrdata},
        {1'b1, 1'b0, 32'h0});
    rst0 = 0; rst2 = 0;

    for (int i = 0; i < WIN; i += 4)
      txq.push_back(mk(1, i, 3'd2, $urandom));
    txq.push_back(mk(1, 32'h10, 3'd2, 32'hDEADBEEF));
    txq.push_back(mk(0, 32'h10, 3'd2, 0));
    txq.push_back(mk(1, 32'h10, 3'd2, 32'h11223344));
    txq.push_back(mk(1, 32'h13, 3'd0, lanes(32'hAA, 32'h13, 0)));
    txq.push_back(mk(0, 32'h10, 3'd2, 0));
    txq.push_back(mk(1, 32'h10, 3'd1, lanes(32'h5566, 32'h10, 1)));
    txq.push_back(mk(0, 32'h10, 3'd2, 0));
    for (int k = 0; k < 4; k++)
      txq.push_back(mk(1, 32'h20 + 4*k, 3'd2, k + 1,
                       k == 0 ? 2'd2 : 2'd3, 3'd3));
    for (int k = 0; k < 4; k++)
      txq.push_back(mk(0, 32'h20 + 4*k, 3'd2, 0,
                       k == 0 ? 2'd2 : 2'd3, 3'd3));
    txq.push_back(mk(1, LIM, 3'd2, $urandom));
    txq.push_back(mk(0, 32'h02, 3'd2, 0));
    txq.push_back(mk(0, 32'h00, 3'd2, 0));
    txq.push_back(mk(1, 32'h11, 3'd1, $urandom));
    txq.push_back(mk(1, 32'h10, 3'd3, $urandom));
    txq.push_back(mk(0, 32'h10, 3'd2, 0));

    for (int n = 0; n < 400; n++) begin
      int r;
      logic [31:0] a;
      logic [2:0] s;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        txq.push_back(mk_idle($urandom_range(0, 1),
                              2'($urandom_range(0, 1))));
      end else if (r == 1) begin
        txq.push_back(mk_idle(0, 2'd2));
      end else begin
        s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7))
                                       : 3'($urandom_range(0, 2));
        if ($urandom_range(0, 9) == 0)
          a = LIM + $urandom_range(0, 4096);
        else
          a = $urandom_range(0, WIN - 1);
        if (s <= 2 && $urandom_range(0, 7) != 0)
          a = a & ~((32'd1 << s) - 1);
        txq.push_back(mk($urandom_range(0, 1), a, s,
                         $urandom, 2'($urandom_range(2, 3))));
      end
    end

    @(posedge hclk); #1;
    mon_en = 1;
    cur = pop_or_idle();
    present(cur);
    dph_v = 0;
    stall = 0;
    while (txq.size() > 0 || is_x(cur) || dph_v) begin
      @(negedge hclk);
      rdy = m0.hreadyout;
      @(posedge hclk); #1;
      if (rdy) begin
        stall = 0;
        if (is_x(cur)) on_accept(cur);
        dph = cur;
        dph_v = is_x(cur);
        cur = pop_or_idle();
        present(cur);
        m0.hwdata = (dph_v && dph.write) ? dph.wdata : $urandom;
      end else begin
        stall++;
        if (stall > 10) begin
          fail_now("u0_stall: hreadyout stuck low");
          break;
        end
      end
    end
    repeat (3) @(negedge hclk);
    chk("sb_drain", sb.size(), 0);

    @(posedge hclk); #1;
    u2_xfer(1, 32'h40, 32'hCAFEF00D, w, rd, rs);
    chk("u2_wr_waits", w, 2);
    chk("u2_wr_resp", rs, 0);
    u2_xfer(0, 32'h40, 32'h0, w, rd, rs);
    chk("u2_rd_waits", w, 2);
    chk("u2_rd_data", rd, 32'hCAFEF00D);
    chk("u2_rd_resp", rs, 0);
    u2_xfer(0, 32'h42, 32'h0, w, rd, rs);
    chk("u2_err_nowait", w, 1);
    chk("u2_err_resp", rs, 1);

    m2.hsel = 1; m2.htrans = 2'd2; m2.haddr = 32'h40;
    m2.hwrite = 1; m2.hsize = 3'd2;
    @(posedge hclk); #1;
    m2.hsel = 0; m2.htrans = 2'd0; m2.hwdata = 32'h12345678;
    @(negedge hclk);
    chk("u2_wait_low", m2.hreadyout, 0);
    rst2 = 1;
    @(negedge hclk);
    chk("u2_rst_mid", {m2.hreadyout, m2.hresp, m2.hrdata},
        {1'b1, 1'b0, 32'h0});
    rst2 = 0;
    @(posedge hclk); #1;
    u2_xfer(0, 32'h40, 32'h0, w, rd, rs);
    chk("u2_no_commit", rd, 32'hCAFEF00D);
    chk("u2_post_rst_waits", w, 2);

    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ahb_inf.md
# ahb_inf

AHB-Lite slave endpoint with local word-addressed memory and a protocol-compliant address/data pipeline. It sits behind the bus interface that the test environment drives (DRV) and observes (MON), and is the target of all AHB-Lite transfers in the block-level bench. It supports single and burst transfers, byte/halfword/word sizes, configurable wait states, and an ERROR response for out-of-range accesses.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HWDATA/HRDATA width (fixed 32 for this block)
- MEM_DEPTH, 256, number of 32-bit words; valid byte addresses 0 .. 4*MEM_DEPTH-1
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per NONSEQ/SEQ transfer (0..7)
- hclk  in  1  single clock, all state on rising edge
- hresetn  in  1  reset, synchronous, active-high (asserted = 1 resets on next rising hclk)
- hsel  in  1  slave select
- haddr  in  ADDR_WIDTH  transfer address
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  in  1  1 = write, 0 = read
- hsize  in  3  0=byte, 1=halfword, 2=word; >2 = ERROR
- hburst  in  3  burst type; accepted, not checked
- hprot  in  4  ignored
- hwdata  in  DATA_WIDTH  write data (data phase)
- hready  in  1  bus HREADY (previous transfer complete)
- hrdata  out  DATA_WIDTH  read data (data phase)
- hreadyout  out  1  slave ready
- hresp  out  1  0 = OKAY, 1 = ERROR

## Operation
- Address phase sampled when hsel & hready & htrans[1] on rising hclk; registers addr, write, size, and a valid flag. IDLE/BUSY or hsel=0 -> no transfer, OKAY, zero wait.
- Error check at address phase: addr >= 4*MEM_DEPTH, hsize > 2, or misalignment (halfword addr[0]=1; word addr[1:0]!=0) -> transfer flagged error; memory untouched.
- Write: in data phase final cycle (hreadyout=1), hwdata byte lanes written per size and addr[1:0], little-endian (byte n at hwdata[8n+7:8n]). Other bytes preserved.
- Read: hrdata = full 32-bit word at registered addr[..:2] during data phase; master selects lanes. hrdata = 0 when no read data phase active.
- Memory contents not cleared by reset; contents undefined until written (bench writes before reading).
- Wait states: counter loads WAIT_STATES on accepted transfer; hreadyout low while counter > 0; decrements each cycle.
- ERROR response: two-cycle. Cycle 1: hresp=1, hreadyout=0. Cycle 2: hresp=1, hreadyout=1. Wait states are not applied to errored transfers.
- Master cancelling (IDLE) after error cycle 1 is honored: no new transfer captured because hready=0 during cycle 1.

## Timing
- Reset (hresetn=1 at edge): hreadyout=1, hresp=0, hrdata=0, valid flag=0, wait counter=0. Reset mid-transfer aborts it; pending write not committed.
- Zero-wait latency: address phase at edge N, data phase cycle N..N+1; read data valid in cycle after address phase; write committed at edge ending data phase.
- Back-to-back pipelining: new address phase accepted on same edge that completes previous data phase.
- Read-after-write to same address in consecutive transfers returns the newly written data (forward hwdata or stall one cycle; forwarding required, no extra wait).
- hreadyout/hresp are registered outputs; hrdata driven from registered address.

## Test plan
- Reset: hold hresetn=1 two cycles -> hreadyout=1, hresp=0, hrdata=0.
- Word write 0xDEADBEEF to 0x10, then read 0x10 -> hrdata=0xDEADBEEF, hresp=0, zero-wait each.
- Byte write 0xAA to 0x13 over word 0x11223344 at 0x10 -> read 0x10 = 0xAA223344; halfword 0x5566 to 0x10 -> 0xAA225566.
- INCR4 burst writes 1,2,3,4 at 0x20..0x2C then INCR4 read -> 1,2,3,4 back-to-back, read-after-write forwarding correct.
- Out-of-range write at 4*MEM_DEPTH and misaligned word read at 0x02 -> two-cycle ERROR (hresp=1 both, hreadyout 0 then 1); memory unchanged.
- WAIT_STATES=2: single read -> hreadyout low 2 cycles, data valid when hreadyout=1; reset asserted mid-wait -> hreadyout=1, write not committed.
